cursor_stepper: RTL
===================

Name: cursor_stepper

Overview:
Parametrised cursor-position engine for the OLED drawing layer. It owns the cursor X/Y registers, which were previously fed back externally, and steps them from the four direction buttons. Steps are single-shot on press, followed by auto-repeat while a button is held. Step size is selectable, the edge mode is either clamp or wrap, diagonal motion is supported, and an external load port allows direct positioning. Its outputs drive the pixel-highlight logic and the drawing-mode FSM.

Parameters:
W, 96, screen width in pixels; X range 0..W-1
H, 64, screen height in pixels; Y range 0..H-1
COORD_W, 8, coordinate width; requires W and H <= 2^COORD_W
X_INIT, 48, reset X; must be < W
Y_INIT, 32, reset Y; must be < H
HOLD_CYCLES, 10000000, synced cycles of hold before auto-repeat starts; >= 2
REPEAT_CYCLES, 2500000, cycles between auto-repeat steps; >= 1
CNT_W, 32, width of the hold/repeat counter

Ports:
CLOCK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
btnL, btnR, btnU, btnD  in  1 each  direction buttons, debounced but asynchronous
lock  in  1  1 = ignore buttons (mode switch)
wrap  in  1  0 = clamp at edges, 1 = wrap modulo W/H
step_sel  in  2  step size: 0->1, 1->2, 2->4, 3->8
load_en  in  1  single-cycle load strobe
load_x, load_y  in  COORD_W each  load values
pos_x, pos_y  out  COORD_W each  current cursor position
moved  out  1  one-cycle pulse when the position changed due to a step
edge_hit  out  1  one-cycle pulse when a clamp limited a step

Behaviour:
- Reset, asserted asynchronously:
  - pos_x = X_INIT, pos_y = Y_INIT
  - moved = 0, edge_hit = 0
  - FSM = IDLE, counter = 0, sync flops = 0
- Button synchronisers: each button and lock passes through a 2-flop synchroniser. Everything below uses the synced values.
- Direction decode:
  - dx = R - L, dy = D - U, each in {-1, 0, +1}; L+R together cancels, as does U+D.
  - active = !lock && (dx != 0 || dy != 0).
- Step: applies signed step s (1/2/4/8 per current step_sel) to both axes, using dx/dy sampled in the step cycle. A direction change while held takes effect at the next step without restarting timing.
- Arithmetic is done at COORD_W+1 bits.
- Clamp mode:
  - Increasing: if v+s > MAX then MAX.
  - Decreasing: if v < s then 0.
  - edge_hit pulses if either axis was limited.
- Wrap mode:
  - Increasing: if v+s >= N then v+s-N.
  - Decreasing: if v < s then v+N-s.
  - edge_hit stays 0.
- moved = 1 in the cycle after a step only if pos_x or pos_y actually changed.
- FSM:
  - IDLE: if active, step now and go to DELAY with counter = 0.
  - DELAY: if !active, go to IDLE. Otherwise counter++; when counter == HOLD_CYCLES-1, step, clear the counter and go to REPEAT.
  - REPEAT: if !active, go to IDLE. Otherwise counter++; when counter == REPEAT_CYCLES-1, step and clear the counter.
- Step timing: while active for N consecutive synced cycles, numbered 0..N-1, steps occur at cycles 0, HOLD_CYCLES, and HOLD_CYCLES + k*REPEAT_CYCLES.
- Latency: a button rising before edge k updates pos at edge k+2 (2 sync stages, then the registered step).
- Lock asserted mid-hold: the FSM goes to IDLE on the first synced-lock cycle and no step occurs in that cycle.
- load_en has priority over stepping:
  - pos takes min(load, MAX) per axis, the FSM goes to IDLE, the counter clears, and no step occurs that cycle.
  - moved = 0 and edge_hit = 0 for the load.
  - If buttons are still held, IDLE steps again on the next cycle.
- Reset asserted mid-hold: immediate return to reset values. After release, the FSM restarts from IDLE.

Decomposition:
- Shared package cursor_pkg holds:
  - FSM state encoding (IDLE/DELAY/REPEAT)
  - step_sel decode constants
  - screen defaults W=96, H=64
- One sub-module, axis_step: a combinational per-axis step unit with inputs v, dir, s, wrap and limit N, producing the next value and a clamped flag. It is instantiated twice, once for X and once for Y.
- The synchroniser uses the existing 2-flop sync cell.

Test Plan:
All scenarios use W=96, H=64, HOLD_CYCLES=10, REPEAT_CYCLES=4.
1. Reset: RESETN=0 mid-run -> pos=(48,32) immediately; moved=0, edge_hit=0.
2. btnR high for 5 cycles, step_sel=0 -> pos_x=49 at the 3rd edge after press; exactly one moved pulse.
3. btnL held 30 synced cycles from (48,32), step_sel=0 -> steps at cycles 0,10,14,18,22,26; final pos_x=42; 6 moved pulses.
4. Load (95,63), then btnR and btnD in clamp mode -> pos stays (95,63); edge_hit=1, moved=0. Then btnU+btnL with step_sel=3 -> (87,55).
5. wrap=1, load (95,0), step_sel=2, btnR+btnU -> pos=(3,60); edge_hit=0, moved=1.
6. btnL+btnR together -> no move, FSM stays IDLE. Hold btnR and raise lock at cycle 12 -> steps at cycles 0 and 10 only; final x = start+2.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor stepper: FSM encoding, step-size decode
// and default screen geometry.
package cursor_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } state_e;

    localparam logic [1:0] StepSel1 = 2'd0;
    localparam logic [1:0] StepSel2 = 2'd1;
    localparam logic [1:0] StepSel4 = 2'd2;
    localparam logic [1:0] StepSel8 = 2'd3;

    localparam int unsigned ScreenW = 96;
    localparam int unsigned ScreenH = 64;

    function automatic logic [3:0] step_size(input logic [1:0] sel);
        logic [3:0] s;
        s = 4'd1;
        unique case (sel)
            StepSel1: s = 4'd1;
            StepSel2: s = 4'd2;
            StepSel4: s = 4'd4;
            StepSel8: s = 4'd8;
            default:  s = 4'd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cursor_stepper_if.sv
// Control/status bundle between the drawing layer and the cursor stepper.
interface cursor_stepper_if #(
    parameter int unsigned COORD_W = 8
);
    logic               btnL;
    logic               btnR;
    logic               btnU;
    logic               btnD;
    logic               lock;
    logic               wrap;
    logic [1:0]         step_sel;
    logic               load_en;
    logic [COORD_W-1:0] load_x;
    logic [COORD_W-1:0] load_y;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               moved;
    logic               edge_hit;

    modport master (
        output btnL, btnR, btnU, btnD, lock, wrap, step_sel, load_en, load_x, load_y,
        input  pos_x, pos_y, moved, edge_hit
    );

    modport slave (
        input  btnL, btnR, btnU, btnD, lock, wrap, step_sel, load_en, load_x, load_y,
        output pos_x, pos_y, moved, edge_hit
    );
endinterface

// File: rtl/axis_step.sv
// Combinational single-axis step: applies +/-s to v with clamp or modulo-n wrap.
module axis_step #(
    parameter int unsigned COORD_W = 8
) (
    input  logic [COORD_W-1:0] v_i,
    input  logic signed [1:0]  dir_i,
    input  logic [3:0]         s_i,
    input  logic               wrap_i,
    input  logic [COORD_W:0]   n_i,
    output logic [COORD_W-1:0] nxt_o,
    output logic               clamped_o
);
    logic [COORD_W:0] v_ext;
    logic [COORD_W:0] s_ext;
    logic [COORD_W:0] sum;
    logic [COORD_W:0] max_v;
    logic [COORD_W:0] res;

    assign v_ext = {1'b0, v_i};
    assign s_ext = (COORD_W+1)'(s_i);
    assign sum   = v_ext + s_ext;
    assign max_v = n_i - 1'b1;

    always_comb begin
        res       = v_ext;
        clamped_o = 1'b0;
        if (dir_i == 2'sb01) begin
            if (wrap_i) begin
                res = (sum >= n_i) ? (sum - n_i) : sum;
            end else if (sum > max_v) begin
                res       = max_v;
                clamped_o = 1'b1;
            end else begin
                res = sum;
            end
        end else if (dir_i == 2'sb11) begin
            if (v_ext >= s_ext) begin
                res = v_ext - s_ext;
            end else if (wrap_i) begin
                res = v_ext + n_i - s_ext;
            end else begin
                res       = '0;
                clamped_o = 1'b1;
            end
        end
    end

    assign nxt_o = res[COORD_W-1:0];
endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser cell for asynchronous single-bit inputs (vectorised).
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/cursor_stepper.sv
// Cursor position engine: synchronised buttons drive an IDLE/DELAY/REPEAT
// stepper with single-shot, hold delay and auto-repeat; load port overrides.
module cursor_stepper
    import cursor_pkg::*;
#(
    parameter int unsigned W             = ScreenW,
    parameter int unsigned H             = ScreenH,
    parameter int unsigned COORD_W       = 8,
    parameter int unsigned X_INIT        = 48,
    parameter int unsigned Y_INIT        = 32,
    parameter int unsigned HOLD_CYCLES   = 10000000,
    parameter int unsigned REPEAT_CYCLES = 2500000,
    parameter int unsigned CNT_W         = 32
) (
    input logic             CLOCK,
    input logic             RESETN,
    cursor_stepper_if.slave bus
);
    localparam logic [COORD_W-1:0] MaxX     = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] MaxY     = COORD_W'(H - 1);
    localparam logic [COORD_W:0]   LimX     = (COORD_W+1)'(W);
    localparam logic [COORD_W:0]   LimY     = (COORD_W+1)'(H);
    localparam logic [CNT_W-1:0]   HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RepLast  = CNT_W'(REPEAT_CYCLES - 1);

    logic [4:0] sync_q;
    logic       s_l, s_r, s_u, s_d, s_lock;

    sync_2ff #(
        .Width (5)
    ) u_sync (
        .clk_i  (CLOCK),
        .rst_ni (RESETN),
        .d_i    ({bus.lock, bus.btnD, bus.btnU, bus.btnR, bus.btnL}),
        .q_o    (sync_q)
    );

    assign {s_lock, s_d, s_u, s_r, s_l} = sync_q;

    logic signed [1:0] dx, dy;
    logic              active;

    // Opposing buttons cancel rather than favouring one direction.
    always_comb begin
        dx = 2'sb00;
        dy = 2'sb00;
        if (s_r && !s_l) dx = 2'sb01;
        if (s_l && !s_r) dx = 2'sb11;
        if (s_d && !s_u) dy = 2'sb01;
        if (s_u && !s_d) dy = 2'sb11;
    end

    assign active = !s_lock && ((dx != 2'sb00) || (dy != 2'sb00));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic               moved_q, moved_d;
    logic               edge_hit_q, edge_hit_d;
    logic               do_step;

    logic [3:0]         step_s;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               clamp_x, clamp_y;

    assign step_s = step_size(bus.step_sel);

    axis_step #(
        .COORD_W (COORD_W)
    ) u_axis_x (
        .v_i       (pos_x_q),
        .dir_i     (dx),
        .s_i       (step_s),
        .wrap_i    (bus.wrap),
        .n_i       (LimX),
        .nxt_o     (nxt_x),
        .clamped_o (clamp_x)
    );

    axis_step #(
        .COORD_W (COORD_W)
    ) u_axis_y (
        .v_i       (pos_y_q),
        .dir_i     (dy),
        .s_i       (step_s),
        .wrap_i    (bus.wrap),
        .n_i       (LimY),
        .nxt_o     (nxt_y),
        .clamped_o (clamp_y)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        moved_d    = 1'b0;
        edge_hit_d = 1'b0;
        do_step    = 1'b0;

        if (bus.load_en) begin
            pos_x_d = (bus.load_x > MaxX) ? MaxX : bus.load_x;
            pos_y_d = (bus.load_y > MaxY) ? MaxY : bus.load_y;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (active) begin
                        do_step = 1'b1;
                        state_d = StDelay;
                        cnt_d   = '0;
                    end
                end
                StDelay: begin
                    if (!active) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == HoldLast) begin
                        do_step = 1'b1;
                        state_d = StRepeat;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!active) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == RepLast) begin
                        do_step = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase

            if (do_step) begin
                pos_x_d    = nxt_x;
                pos_y_d    = nxt_y;
                moved_d    = (nxt_x != pos_x_q) || (nxt_y != pos_y_q);
                edge_hit_d = clamp_x || clamp_y;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pos_x_q    <= COORD_W'(X_INIT);
            pos_y_q    <= COORD_W'(Y_INIT);
            moved_q    <= 1'b0;
            edge_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            moved_q    <= moved_d;
            edge_hit_q <= edge_hit_d;
        end
    end

    assign bus.pos_x    = pos_x_q;
    assign bus.pos_y    = pos_y_q;
    assign bus.moved    = moved_q;
    assign bus.edge_hit = edge_hit_q;
endmodule
